// File: rtl/piso_ser_day7_if.sv
// Handshake and serial-output bundle for the parallel-in serial-out stage.
// Ports: in_valid/in_data/msb_first/hold driven upstream (master); in_ready,
//        ser_out/ser_valid/ser_last/busy/word_cnt driven by the serializer (slave).
interface piso_ser_day7_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             msb_first;
  logic             in_ready;
  logic             hold;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output in_valid, in_data, msb_first, hold,
    input  in_ready, ser_out, ser_valid, ser_last, busy, word_cnt
  );

  modport slave (
    input  in_valid, in_data, msb_first, hold,
    output in_ready, ser_out, ser_valid, ser_last, busy, word_cnt
  );
endinterface

// File: rtl/piso_ser_day7.sv
// Parallel-in serial-out: accepts a WIDTH-bit word per valid/ready handshake and
// emits it one bit per clock, MSB- or LSB-first per word, with hold back-pressure.
// Ports: clk, reset (async active-high), bus (slave side of piso_ser_day7_if).
module piso_ser_day7 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  piso_ser_day7_if.slave   bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             msb_q, msb_d;
  logic             ser_q, ser_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic last_bit;
  logic advance;
  logic ready;
  logic accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      msb_q     <= 1'b0;
      ser_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      msb_q     <= msb_d;
      ser_q     <= ser_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    msb_d     = msb_q;
    cnt_d     = cnt_q;

    last_bit = (bit_cnt_q == LAST_IDX);
    advance  = (state_q == SHIFT) && !bus.hold;
    // Ready depends only on state, counter, hold and reset; never on in_valid.
    ready    = !reset && ((state_q == IDLE) || (advance && last_bit));
    accept   = bus.in_valid && ready;

    if (advance) begin
      sreg_d    = msb_q ? (sreg_q << 1) : (sreg_q >> 1);
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
      if (last_bit) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
    end

    // A load on the final bit overrides the return to IDLE: zero-bubble chaining.
    if (accept) begin
      sreg_d    = bus.in_data;
      msb_d     = bus.msb_first;
      bit_cnt_d = '0;
      state_d   = SHIFT;
    end

    // Pre-select the next serial bit so ser_out comes straight from a flop.
    // Once a word is fully shifted out the register is zero, so IDLE shows 0.
    ser_d = msb_d ? sreg_d[WIDTH-1] : sreg_d[0];
  end

  assign bus.in_ready  = ready;
  assign bus.ser_out   = ser_q;
  assign bus.ser_valid = advance;
  assign bus.ser_last  = advance && last_bit;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.word_cnt  = cnt_q;
endmodule
